// File: rtl/gf283_reduce_if.sv
// Handshake bundle for the GF(2^283) reduction stage: product in, residue out.
interface gf283_reduce_if;
  localparam int unsigned M  = 283;
  localparam int unsigned PW = 2 * M - 1;

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_res;
  logic          busy;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/gf283_reduce.sv
// Reduces a 565-bit carry-less product mod x^283 + x^12 + x^7 + x^5 + 1 in two folds.
// Define GF283_REDUCE_ONE_CYCLE_EN to perform both folds in a single FOLD1 cycle.
module gf283_reduce (
  input logic           clk,
  input logic           rst_n,
  gf283_reduce_if.slave bus
);
  localparam int unsigned M  = 283;
  localparam int unsigned K1 = 12;
  localparam int unsigned K2 = 7;
  localparam int unsigned K3 = 5;
  localparam int unsigned PW = 2 * M - 1;
  // First-fold result width: top product bit (PW-1-M) shifted up by K1.
  localparam int unsigned TW = PW - M + K1;

  typedef enum logic [1:0] {StIdle, StFold1, StFold2, StHold} state_e;

  function automatic logic [TW-1:0] fold1(input logic [PW-1:0] c);
    logic [TW-1:0] h;
    h = TW'(c[PW-1:M]);
    return TW'(c[M-1:0]) ^ h ^ (h << K3) ^ (h << K2) ^ (h << K1);
  endfunction

  // Overflow from the first fold is only 11 bits, so the shifted taps stay below bit 23.
  function automatic logic [M-1:0] fold2(input logic [TW-1:0] t);
    logic [M-1:0] h;
    h = M'(t[TW-1:M]);
    return t[M-1:0] ^ h ^ (h << K3) ^ (h << K2) ^ (h << K1);
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [M-1:0]  res_q, res_d;
`ifndef GF283_REDUCE_ONE_CYCLE_EN
  logic [TW-1:0] t_q, t_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      res_q   <= '0;
`ifndef GF283_REDUCE_ONE_CYCLE_EN
      t_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
`ifndef GF283_REDUCE_ONE_CYCLE_EN
      t_q     <= t_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifndef GF283_REDUCE_ONE_CYCLE_EN
    t_d     = t_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_prod;
          state_d = StFold1;
        end
      end
      StFold1: begin
`ifdef GF283_REDUCE_ONE_CYCLE_EN
        res_d   = fold2(fold1(acc_q));
        state_d = StHold;
`else
        t_d     = fold1(acc_q);
        state_d = StFold2;
`endif
      end
      StFold2: begin
`ifdef GF283_REDUCE_ONE_CYCLE_EN
        state_d = StIdle;
`else
        res_d   = fold2(t_q);
        state_d = StHold;
`endif
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_res   = res_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_gf283_reduce.sv
// Directed-vector and randomized-stream bench for gf283_reduce.
module tb_gf283_reduce;
  localparam int unsigned M     = 283;
  localparam int unsigned PW    = 2 * M - 1;
  localparam int          NRAND = 3000;
`ifdef GF283_REDUCE_ONE_CYCLE_EN
  localparam int          LAT   = 2;
`else
  localparam int          LAT   = 3;
`endif

  typedef struct {
    logic [PW-1:0] prod;
    logic [M-1:0]  exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gf283_reduce_if bus ();

  gf283_reduce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pbit(input int idx);
    logic [PW-1:0] p;
    p = '0;
    p[idx] = 1'b1;
    return p;
  endfunction

  function automatic logic [M-1:0] rbit(input int idx);
    logic [M-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Bit-serial long division by f(x), independent of the two-fold structure.
  function automatic logic [M-1:0] ref_mod(input logic [PW-1:0] c);
    logic [PW-1:0] v;
    v = c;
    for (int i = PW - 1; i >= M; i--) begin
      if (v[i]) begin
        v[i]          = 1'b0;
        v[i - M]      = v[i - M] ^ 1'b1;
        v[i - M + 5]  = v[i - M + 5] ^ 1'b1;
        v[i - M + 7]  = v[i - M + 7] ^ 1'b1;
        v[i - M + 12] = v[i - M + 12] ^ 1'b1;
      end
    end
    return v[M-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_prod();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < 18; i++) p = (p << 32) | PW'($urandom);
    if ($urandom_range(7) == 0) p[PW-1:M] = '0;
    return p;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns residue and accept-to-valid latency.
  task automatic send(input logic [PW-1:0] p, output logic [M-1:0] res, output int lat);
    int w;
    bus.in_prod   = p;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_res;
    @(posedge clk); #1;
  endtask

  vec_t          vecs[9];
  logic [M-1:0]  res;
  logic [M-1:0]  exp_r;
  logic [PW-1:0] pa, pb;
  int            lat, w, sent, got, cyc;
  bit            take;
  logic [M-1:0]  q[$];

  initial begin
    errors = 0;
    checks = 0;

    vecs[0].prod = pbit(0);                vecs[0].exp = rbit(0);
    vecs[1].prod = pbit(283);              vecs[1].exp = 283'h10A1;
    vecs[2].prod = pbit(564);
    vecs[2].exp  = rbit(281) | rbit(22) | rbit(12) | rbit(10) | rbit(8) | rbit(5) | rbit(3);
    vecs[3].prod = pbit(282);              vecs[3].exp = rbit(282);
    vecs[4].prod = pbit(284);              vecs[4].exp = 283'h2142;
    vecs[5].prod = pbit(294);              vecs[5].exp = rbit(23) | rbit(18) | rbit(16) | rbit(11);
    vecs[6].prod = pbit(555);
    vecs[6].exp  = rbit(279) | rbit(277) | rbit(272) | rbit(13) | rbit(8) | rbit(6) | rbit(1);
    vecs[7].prod = pbit(283) | pbit(0);    vecs[7].exp = 283'h10A0;
    vecs[8].prod = PW'({M{1'b1}});         vecs[8].exp = {M{1'b1}};

    // Reset held with inputs toggling
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_prod = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.in_prod   = rand_prod();
      #1;
      check("reset_in_ready", PW'(bus.in_ready), PW'(1));
      check("reset_out_valid", PW'(bus.out_valid), PW'(0));
      check("reset_out_res", PW'(bus.out_res), PW'(0));
      check("reset_busy", PW'(bus.busy), PW'(0));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].prod, res, lat);
      check($sformatf("vec%0d_res", i), PW'(res), PW'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), PW'(lat), PW'(LAT));
      check($sformatf("vec%0d_idle", i), PW'({bus.out_valid, bus.busy}), PW'(0));
    end

    // Back-pressure: second product must wait for the first to drain
    pa = pbit(564) | pbit(1);
    pb = pbit(300) | pbit(7);
    bus.in_prod = pa; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_prod = pb;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_valid_seen", PW'(bus.out_valid), PW'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", PW'(bus.out_res), PW'(ref_mod(pa)));
      check("bp_hold_ctl", PW'({bus.in_ready, bus.out_valid}), PW'(2'b01));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", PW'({bus.in_ready, bus.out_valid}), PW'(2'b10));
    check("bp_res_kept", PW'(bus.out_res), PW'(ref_mod(pa)));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_accept", PW'(bus.busy), PW'(1));
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_second_res", PW'(bus.out_res), PW'(ref_mod(pb)));
    @(posedge clk); #1;

    // Reset mid-operation
    bus.in_prod = rand_prod() | pbit(564); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
`ifndef GF283_REDUCE_ONE_CYCLE_EN
    @(posedge clk); #1;
`endif
    check("midrst_busy_before", PW'(bus.busy), PW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_state", PW'({bus.in_ready, bus.out_valid, bus.busy}), PW'(3'b100));
    check("midrst_res", PW'(bus.out_res), PW'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", PW'(bus.out_valid), PW'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(pbit(0), res, lat);
    check("midrst_after_res", PW'(res), PW'(1));
    check("midrst_after_lat", PW'(lat), PW'(LAT));

    // Random stream with output stalls; scoreboard catches loss and duplication
    sent = 0; got = 0; cyc = 0;
    bus.in_valid = 1'b0;
    while (got < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!bus.in_valid && sent < NRAND && $urandom_range(7) != 0) begin
        bus.in_prod  = rand_prod();
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_extra: got %h expected none", bus.out_res);
        end else begin
          exp_r = q.pop_front();
          check("rand_res", PW'(bus.out_res), PW'(exp_r));
        end
        got++;
      end
      take = bus.in_valid && bus.in_ready;
      if (take) begin
        q.push_back(ref_mod(bus.in_prod));
        sent++;
      end
      @(posedge clk); #1;
      if (take) bus.in_valid = 1'b0;
    end
    check("rand_count", PW'(got), PW'(NRAND));
    check("rand_queue_empty", PW'(q.size()), PW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
